// File: rtl/tsp_cost_display.sv
// Best-tour cost to six active-low 7-seg digits via bit-serial double-dabble; optional TSP_DISP_LZB_EN blanks leading zeros.
// Latency WIDTH+1 cycles accept-to-display; in_ready only in IDLE, so one cost per WIDTH+2 cycles.
module tsp_cost_display #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_cost,
  output logic             busy,
  output logic             ovf,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3,
  output logic [6:0]       HEX4,
  output logic [6:0]       HEX5
);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] bin;
  logic [23:0]      bcd;
  logic [23:0]      bcd_adj;
  logic [CW-1:0]    cnt;
  logic             ovf_pending;
  logic [41:0]      disp;
  logic [3:0]       dig;
`ifdef TSP_DISP_LZB_EN
  logic             leading;
`endif

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
  endfunction

  // Add-3 correction applied to each nibble before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 6; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    disp = {6{7'h7F}};
    dig  = 4'd0;
`ifdef TSP_DISP_LZB_EN
    leading = 1'b1;
`endif
    for (int i = 5; i >= 0; i--) begin
      dig = bcd[4*i +: 4];
`ifdef TSP_DISP_LZB_EN
      if (leading && dig == 4'd0 && i != 0) begin
        disp[7*i +: 7] = 7'h7F;
      end else begin
        leading        = 1'b0;
        disp[7*i +: 7] = seg(dig);
      end
`else
      disp[7*i +: 7] = seg(dig);
`endif
    end
    if (ovf_pending) disp = {6{7'h3F}};
  end

  assign in_ready = (state == IDLE);
  assign busy     = !in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bin         <= '0;
      bcd         <= '0;
      cnt         <= '0;
      ovf_pending <= 1'b0;
      ovf         <= 1'b0;
      {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} <= {6{7'h7F}};
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin         <= in_cost;
            bcd         <= '0;
            cnt         <= CW'(WIDTH);
            ovf_pending <= (32'(in_cost) > 32'd999999);
            state       <= CONV;
          end
        end
        CONV: begin
          {bcd, bin} <= {bcd_adj, bin} << 1;
          cnt        <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= COMMIT;
        end
        COMMIT: begin
          {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} <= disp;
          ovf   <= ovf_pending;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tsp_cost_display.sv
// Self-checking bench for tsp_cost_display: directed table, hand-written corner sequences, randomized costs vs. a decimal model.
module tb_tsp_cost_display;
  localparam int W = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_cost = '0;
  logic         busy;
  logic         ovf;
  logic [6:0]   HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  int tests = 0;
  int fails = 0;

  tsp_cost_display #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_cost(in_cost), .busy(busy), .ovf(ovf),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
  );

  always #5 clk = ~clk;

  wire [41:0] hex_all = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  typedef struct {
    int unsigned cost;
    logic [41:0] hex;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: decimal digits by division, segment lookup, optional leading-zero blanking.
  function automatic logic [41:0] model_hex(input int unsigned c);
    logic [6:0] segtab [10];
    int unsigned d [6];
    int unsigned v;
    int top;
    logic [41:0] r;
    segtab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    if (c > 999999) return {6{7'h3F}};
    v = c;
    top = 0;
    for (int i = 0; i < 6; i++) begin
      d[i] = v % 10;
      v = v / 10;
      if (d[i] != 0) top = i;
    end
    r = '0;
    for (int i = 0; i < 6; i++) begin
      r[7*i +: 7] = segtab[d[i]];
`ifdef TSP_DISP_LZB_EN
      if (i > top) r[7*i +: 7] = 7'h7F;
`endif
    end
    return r;
  endfunction

  // Drives one cost from IDLE and checks handshake timing, hold-during-CONV and the committed result.
  task automatic do_conv(input int unsigned c, input logic [41:0] exp_hex, input logic exp_ovf);
    logic [41:0] prev;
    for (int k = 0; k < 50 && !in_ready; k++) @(negedge clk);
    check("ready_before_accept", 64'(in_ready), 64'd1);
    prev     = hex_all;
    in_valid = 1'b1;
    in_cost  = W'(c);
    for (int e = 0; e <= W; e++) begin
      @(negedge clk);
      if (e == 0) begin
        in_valid = 1'b0;
        in_cost  = W'($urandom);
      end
      check("ready_low_conv", 64'(in_ready), 64'd0);
      check("busy_conv", 64'(busy), 64'd1);
      check("hex_hold_conv", 64'(hex_all), 64'(prev));
    end
    @(negedge clk);
    check("ready_after_commit", 64'(in_ready), 64'd1);
    check("hex_commit", 64'(hex_all), 64'(exp_hex));
    check("ovf_commit", 64'(ovf), 64'(exp_ovf));
  endtask

  initial begin
    int acc2;
    int unsigned c;

`ifdef TSP_DISP_LZB_EN
    vecs[1] = '{42,      {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24}, 1'b0};
    vecs[3] = '{7,       {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78}, 1'b0};
    vecs[4] = '{0,       {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b0};
    vecs[7] = '{100,     {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40}, 1'b0};
`else
    vecs[1] = '{42,      {7'h40, 7'h40, 7'h40, 7'h40, 7'h19, 7'h24}, 1'b0};
    vecs[3] = '{7,       {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h78}, 1'b0};
    vecs[4] = '{0,       {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 1'b0};
    vecs[7] = '{100,     {7'h40, 7'h40, 7'h40, 7'h79, 7'h40, 7'h40}, 1'b0};
`endif
    vecs[0] = '{123456,  {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}, 1'b0};
    vecs[2] = '{1000000, {6{7'h3F}}, 1'b1};
    vecs[5] = '{999999,  {6{7'h10}}, 1'b0};
    vecs[6] = '{1048575, {6{7'h3F}}, 1'b1};

    // Reset held three cycles
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_hex", 64'(hex_all), 64'({6{7'h7F}}));
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);

    foreach (vecs[i]) do_conv(vecs[i].cost, vecs[i].hex, vecs[i].ovf);

    // in_valid held high: 5 then 9, second accept 22 cycles after the first
    in_valid = 1'b1;
    in_cost  = W'(5);
    acc2     = -1;
    @(negedge clk);
    in_cost = W'(9);
    for (int n = 1; n <= 45; n++) begin
      if (n - 1 >= 21 && n - 1 <= 42) check("stream_hex0_first", 64'(HEX0), 64'h12);
      if (n - 1 == 43) check("stream_hex0_second", 64'(HEX0), 64'h10);
      if (in_ready && in_valid && acc2 < 0) acc2 = n;
      @(negedge clk);
      if (acc2 > 0) in_valid = 1'b0;
    end
    check("stream_accept_gap", 64'(acc2), 64'd22);

    // Reset and valid on the same edge: nothing accepted
    rst      = 1'b1;
    in_valid = 1'b1;
    in_cost  = W'(3);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_valid_ready", 64'(in_ready), 64'd1);
    check("rst_valid_hex", 64'(hex_all), 64'({6{7'h7F}}));

    // Reset during the 10th CONV cycle of 999999
    do_conv(7, model_hex(7), 1'b0);
    in_valid = 1'b1;
    in_cost  = W'(999999);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("midrst_still_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_hex", 64'(hex_all), 64'({6{7'h7F}}));
    check("midrst_ready", 64'(in_ready), 64'd1);
    check("midrst_ovf", 64'(ovf), 64'd0);
    do_conv(0, model_hex(0), 1'b0);

    // Randomized costs against the decimal model
    for (int k = 0; k < 40; k++) begin
      c = ($urandom_range(0, 7) == 0) ? $urandom_range(1000000, 1048575) : $urandom_range(0, 999999);
      do_conv(c, model_hex(c), (c > 999999));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tsp_cost_display.md
# tsp_cost_display

Result-side display engine for the FPGA TSP solver. It accepts the solver's best tour cost over a valid/ready handshake and converts it to decimal with a sequential double-dabble (one bit per cycle). It then drives the six board seven-segment digits HEX0..HEX5. It is the consumer end of the solver's result stream, instantiated inside the top-level board wrapper next to the SW/LEDR logic.

## Interface
- WIDTH, 20: cost input width in bits. Legal range 1..20.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  cost word valid.
- in_ready  output  1  block can accept a cost word; high only in IDLE.
- in_cost  input  WIDTH  unsigned tour cost.
- busy  output  1  conversion in progress (CONV or COMMIT).
- ovf  output  1  last committed cost exceeded 999999.
- HEX0..HEX5  output  7 each  segment drive, active-low, bit0=a … bit6=g; HEX0 is the least significant digit.

## Operation
- FSM states and transitions:
  - IDLE -> CONV on the edge where in_valid && in_ready. On that edge the block latches in_cost into the shift register, clears the 24-bit BCD register, sets cnt=WIDTH, and latches ovf_pending = (in_cost > 999999).
  - CONV: each edge first adds 3 to every BCD nibble ≥ 5, then shifts {bcd, bin} left by 1 and decrements cnt. After the edge where cnt reaches 0, the FSM moves to COMMIT.
  - COMMIT -> IDLE: HEX0..HEX5 and ovf are loaded from the BCD register and ovf_pending.
- Digit encoding (hex, active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10. Blank=7F. Dash=3F (segment g only).
- Overflow: if ovf_pending is set, all six digits show dash and ovf=1. Otherwise ovf=0.
- HEX outputs hold the previously committed value for the whole of CONV; they change only on the COMMIT edge.
- in_valid is ignored outside IDLE. in_cost is sampled only on the accept edge, so the source may change it afterwards.
- in_ready = (state == IDLE). busy = !in_ready.
- BCD register is 24 bits (6 nibbles). WIDTH ≤ 20 guarantees no nibble overflow for in-range values. Out-of-range values still run the full conversion, but the result is discarded in favour of dashes.

## Timing
- Reset values: state=IDLE, in_ready=1, busy=0, ovf=0, HEX0..HEX5=7F (blank).
- Accept edge E0. Shift steps occur on edges E1..E_WIDTH. Outputs update on edge E_(WIDTH+1).
- in_ready is low from after E0 until after E_(WIDTH+1). The next accept can occur at E_(WIDTH+2) at the earliest.
- Throughput: one cost per WIDTH+2 cycles. With WIDTH=20 that is 22 cycles.
- rst asserted in any state aborts the conversion at that edge: all outputs return to their reset values and the pending value is lost.
- rst and in_valid high on the same edge: reset wins and nothing is accepted.
- in_valid held high continuously: a new word is accepted on every IDLE edge, i.e. every WIDTH+2 cycles.

## Configuration
- TSP_DISP_LZB_EN (leading-zero blanking).
  - Defined: at COMMIT, every digit above the most significant nonzero digit is driven 7F. A cost of 0 shows 40 on HEX0 and blanks HEX1..HEX5. Dash display for overflow is unaffected.
  - Not defined: all six digits always show their decimal value, including leading zeros (40).

## Test plan
- Reset: hold rst 3 cycles, then release -> HEX0..HEX5=7F, in_ready=1, busy=0, ovf=0.
- in_cost=123456 with WIDTH=20, single-cycle valid ->
  - in_ready=0 for 21 cycles.
  - Exactly 21 edges after the accept edge: HEX5..HEX0 = 79,24,30,19,12,02, ovf=0.
  - HEX stays 7F until that edge.
- in_cost=42 ->
  - With TSP_DISP_LZB_EN: HEX1=19, HEX0=24, HEX2..HEX5=7F.
  - Without it: HEX2..HEX5=40.
- in_cost=1000000 -> all HEX=3F, ovf=1. A following in_cost=7 -> ovf=0, HEX0=78.
- in_valid held high with values 5 then 9 -> the second word is accepted exactly 22 cycles after the first. HEX0 shows 12, then 10, with no intermediate value.
- Assert rst at the 10th CONV cycle of in_cost=999999 -> the next edge gives HEX all 7F and in_ready=1. A new cost of 0 then converts normally.
